// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: Moore control FSM for a 4-tap FIR filter (coeff load, sample shift, MAC chain).
// Optional macro FIR_STICKY_ERR_EN: EIDLE is left only through a coefficient load.
module fir_mac_sequencer #(
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  data_ready,
  input  logic                  load_coeff,
  input  logic                  overflow,
  output logic [2:0]            op,
  output logic [REG_ADDR_W-1:0] src1,
  output logic [REG_ADDR_W-1:0] src2,
  output logic [REG_ADDR_W-1:0] dest,
  output logic                  cnt_up,
  output logic                  clear,
  output logic                  modwait,
  output logic                  err
);
  localparam logic [2:0] NOP = 3'd0, COPY = 3'd1, LD_S = 3'd2, LD_C = 3'd3, ADD = 3'd4, SUB = 3'd5, MUL = 3'd6;
  typedef enum logic [4:0] {
    IDLE, LOADC, STORE, ZERO, SORT1, SORT2, SORT3, SORT4,
    MUL1, ADD1, MUL2, SUB2, MUL3, ADD3, MUL4, SUB4, EIDLE
  } state_t;
  state_t state, next;
  logic [1:0] coeff_idx;
  function automatic logic [REG_ADDR_W-1:0] r(input int i);
    return REG_ADDR_W'(i);
  endfunction
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      coeff_idx <= '0;
    end else begin
      state <= next;
      if (state == LOADC) coeff_idx <= coeff_idx + 2'd1;
    end
  end
  always_comb begin
    next    = IDLE;
    op      = NOP;
    src1    = '0;
    src2    = '0;
    dest    = '0;
    cnt_up  = 1'b0;
    clear   = 1'b0;
    modwait = 1'b1;
    err     = 1'b0;
    case (state)
      IDLE: begin
        modwait = 1'b0;
        next    = load_coeff ? LOADC : data_ready ? STORE : IDLE;
      end
      LOADC: begin
        op    = LD_C;
        dest  = r(6 + int'(coeff_idx));
        clear = coeff_idx == 2'd3;
      end
      STORE: begin
        op   = LD_S;
        dest = r(5);
        next = data_ready ? ZERO : EIDLE;
      end
      ZERO: begin
        op     = SUB;
        cnt_up = 1'b1;
        next   = SORT1;
      end
      SORT1: begin op = COPY; src1 = r(3); dest = r(4); next = SORT2; end
      SORT2: begin op = COPY; src1 = r(2); dest = r(3); next = SORT3; end
      SORT3: begin op = COPY; src1 = r(1); dest = r(2); next = SORT4; end
      SORT4: begin op = COPY; src1 = r(5); dest = r(1); next = MUL1; end
      MUL1:  begin op = MUL; src1 = r(1); src2 = r(6); dest = r(10); next = ADD1; end
      ADD1:  begin op = ADD; src2 = r(10); next = overflow ? EIDLE : MUL2; end
      MUL2:  begin op = MUL; src1 = r(2); src2 = r(7); dest = r(10); next = SUB2; end
      SUB2:  begin op = SUB; src2 = r(10); next = overflow ? EIDLE : MUL3; end
      MUL3:  begin op = MUL; src1 = r(3); src2 = r(8); dest = r(10); next = ADD3; end
      ADD3:  begin op = ADD; src2 = r(10); next = overflow ? EIDLE : MUL4; end
      MUL4:  begin op = MUL; src1 = r(4); src2 = r(9); dest = r(10); next = SUB4; end
      SUB4:  begin op = SUB; src2 = r(10); next = overflow ? EIDLE : IDLE; end
      EIDLE: begin
        modwait = 1'b0;
        err     = 1'b1;
`ifdef FIR_STICKY_ERR_EN
        next    = load_coeff ? LOADC : EIDLE;
`else
        next    = load_coeff ? LOADC : data_ready ? STORE : EIDLE;
`endif
      end
      default: modwait = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: scoreboard bench; transaction tasks expand each load/sample into its cycle trace.
module tb_fir_mac_sequencer;
  logic clk = 1'b0, n_rst = 1'b0, data_ready = 1'b0, load_coeff = 1'b0, overflow = 1'b0;
  logic [2:0] op;
  logic [3:0] src1, src2, dest;
  logic cnt_up, clear, modwait, err;
  typedef logic [18:0] vec_t;
  vec_t q[$];
  vec_t act;
  int checks = 0, errors = 0;
  int cidx = 0;
  bit in_err = 1'b0;

  always #5 clk = ~clk;

  fir_mac_sequencer #(.REG_ADDR_W(4)) dut (
    .clk(clk), .n_rst(n_rst), .data_ready(data_ready), .load_coeff(load_coeff),
    .overflow(overflow), .op(op), .src1(src1), .src2(src2), .dest(dest),
    .cnt_up(cnt_up), .clear(clear), .modwait(modwait), .err(err)
  );

  assign act = {op, src1, src2, dest, cnt_up, clear, modwait, err};

  function automatic vec_t mk(input int o, input int s1, input int s2, input int d,
                              input int c, input int cl, input int mw, input int e);
    return {o[2:0], s1[3:0], s2[3:0], d[3:0], c[0], cl[0], mw[0], e[0]};
  endfunction

  function automatic vec_t idle_e();
    return mk(0, 0, 0, 0, 0, 0, 0, int'(in_err));
  endfunction

  // Busy trace of one sample, index 0 = STORE .. 13 = last MAC line
  function automatic vec_t mac_e(input int i);
    int k;
    if (i == 0) return mk(2, 0, 0, 5, 0, 0, 1, 0);
    if (i == 1) return mk(5, 0, 0, 0, 1, 0, 1, 0);
    if (i < 6) begin
      k = i - 2;
      return mk(1, (k < 3) ? 3 - k : 5, 0, 4 - k, 0, 0, 1, 0);
    end
    k = (i - 6) / 2;
    if ((i - 6) % 2 == 0) return mk(6, k + 1, 6 + k, 10, 0, 0, 1, 0);
    return mk((k % 2 == 1) ? 5 : 4, 0, 10, 0, 0, 0, 1, 0);
  endfunction

  task automatic report(input string name, input vec_t a, input vec_t e);
    $display("FAIL %s: got op=%0d s1=%0d s2=%0d d=%0d cnt=%0b clr=%0b mw=%0b err=%0b, expected op=%0d s1=%0d s2=%0d d=%0d cnt=%0b clr=%0b mw=%0b err=%0b",
             name, a[18:16], a[15:12], a[11:8], a[7:4], a[3], a[2], a[1], a[0],
             e[18:16], e[15:12], e[11:8], e[7:4], e[3], e[2], e[1], e[0]);
  endtask

  always @(negedge clk) begin
    vec_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        report("trace", act, e);
      end
    end
  end

  task automatic step(input vec_t e, input bit lc, input bit dr, input bit ov);
    load_coeff = lc;
    data_ready = dr;
    overflow   = ov;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(idle_e(), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_load(input bit hold_dr);
    step(idle_e(), 1'b1, hold_dr, 1'b0);
    step(mk(3, 0, 0, 6 + cidx, 0, int'(cidx == 3), 1, 0), 1'($urandom % 2), hold_dr, 1'($urandom % 2));
    cidx   = (cidx + 1) % 4;
    in_err = 1'b0;
  endtask

  task automatic do_sample(input int ov_at, input bit drop, input int rst_at);
    bit chk;
    step(idle_e(), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) begin
      chk = (i >= 7) && (i % 2 == 1);
      if (i == rst_at) begin
        load_coeff = 1'b0;
        data_ready = 1'b0;
        overflow   = 1'b0;
        q.push_back(mac_e(i));
        @(negedge clk);
        #1 n_rst = 1'b0;
        #1;
        checks++;
        if (act !== '0) begin
          errors++;
          report("async_reset", act, '0);
        end
        in_err = 1'b0;
        cidx   = 0;
        @(posedge clk);
        #1;
        q.push_back(idle_e());
        @(posedge clk);
        #1 n_rst = 1'b1;
        return;
      end
      if (i == 0) begin
        step(mac_e(0), 1'($urandom % 2), !drop, 1'($urandom % 2));
        in_err = drop;
        if (drop) return;
      end else begin
        step(mac_e(i), 1'($urandom % 2), 1'b0, chk ? (i == ov_at) : 1'($urandom % 2));
        if (chk && i == ov_at) begin
          in_err = 1'b1;
          return;
        end
      end
    end
  endtask

  initial begin
    int ov;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (act !== '0) begin
      errors++;
      report("reset_state", act, '0);
    end
    n_rst = 1'b1;
    idle(2);
    repeat (4) begin
      do_load(1'b0);
      idle(2);
    end
    repeat (4) begin
      do_sample(-1, 1'b0, -1);
      idle(1);
    end
    do_sample(11, 1'b0, -1);
    idle(2);
    do_sample(-1, 1'b0, -1);
    do_sample(-1, 1'b1, -1);
    idle(1);
    do_sample(-1, 1'b0, -1);
    do_sample(7, 1'b0, -1);
    do_load(1'b0);
    do_sample(13, 1'b0, -1);
    do_sample(-1, 1'b0, -1);
    do_load(1'b1);
    do_sample(-1, 1'b0, -1);
    do_sample(-1, 1'b0, 8);
    do_load(1'b0);
    idle(1);
    repeat (40) begin
      if ($urandom % 4 == 0) do_load(1'($urandom % 2));
      else begin
        ov = ($urandom % 3 == 0) ? 7 + 2 * int'($urandom % 4) : -1;
        do_sample(ov, ($urandom % 8) == 0, -1);
      end
      idle(int'($urandom % 3));
    end
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Control FSM for the 4-tap FIR filter datapath. It sequences one shared register file and one multiply/add unit through coefficient loads, sample shifting and the multiply-accumulate chain. It drives modwait and err back to the bus-slave side, and consumes data_ready and load_coeff from the slave and coefficient loader. The output is Moore style: op, src1, src2, dest, cnt_up, clear, modwait and err are all decoded from the registered state.

Parameters:
REG_ADDR_W, 4, width of register-file index buses src1/src2/dest.

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
data_ready  in  1  level; new sample on sample bus, held by slave until modwait seen
load_coeff  in  1  one-cycle pulse; coefficient on coefficient bus
overflow  in  1  datapath ALU overflow of the current ADD/SUB op, combinational same cycle
op  out  3  datapath op: 0 NOP, 1 COPY, 2 LOAD_SAMPLE, 3 LOAD_COEFF, 4 ADD, 5 SUB, 6 MUL
src1  out  REG_ADDR_W  operand A register index
src2  out  REG_ADDR_W  operand B register index
dest  out  REG_ADDR_W  destination register index
cnt_up  out  1  one-cycle pulse per accepted sample (sample counter)
clear  out  1  one-cycle pulse when a full coefficient set has been loaded
modwait  out  1  busy; high in every state except IDLE and EIDLE
err  out  1  overflow or dropped-sample error flag

Behaviour:
- Register map:
  - R0: accumulator/result.
  - R1..R4: sample history, R1 newest.
  - R5: incoming sample.
  - R6..R9: coefficients F0..F3.
  - R10: product temp.
- Reset state:
  - State IDLE, coeff_idx=0.
  - All outputs 0. op=NOP, indices 0.
- coeff_idx is a 2-bit counter. It increments on exit from LOADC and wraps 3 to 0.
- IDLE transitions:
  - load_coeff goes to LOADC. It has priority if asserted together with data_ready.
  - data_ready goes to STORE.
  - Otherwise stay in IDLE.
- LOADC:
  - Outputs: op=LOAD_COEFF, dest=6+coeff_idx, modwait=1.
  - clear=1 when coeff_idx==3.
  - Next state is always IDLE.
- STORE:
  - Outputs: op=LOAD_SAMPLE, dest=5.
  - If data_ready==0 while in STORE, go to EIDLE (dropped sample). Otherwise go to ZERO.
- ZERO: SUB R0=R0-R0. cnt_up=1.
- SORT states:
  - SORT1: COPY R4<-R3.
  - SORT2: COPY R3<-R2.
  - SORT3: COPY R2<-R1.
  - SORT4: COPY R1<-R5.
- MAC chain, one state per line:
  - MUL1: R10=R1*R6.
  - ADD1: R0=R0+R10.
  - MUL2: R10=R2*R7.
  - SUB2: R0=R0-R10.
  - MUL3: R10=R3*R8.
  - ADD3: R0=R0+R10.
  - MUL4: R10=R4*R9.
  - SUB4: R0=R0-R10.
- After SUB4, go to IDLE.
- COPY uses src1 as the source and dest as the destination. src2 is 0 for COPY and LOAD.
- Overflow:
  - overflow==1 in any of ADD1/SUB2/ADD3/SUB4 goes to EIDLE next cycle. R0 is left as computed.
  - overflow is ignored in all other states.
- EIDLE:
  - Outputs: err=1, modwait=0, op=NOP.
  - load_coeff goes to LOADC. data_ready goes to STORE.
  - err clears once the state leaves EIDLE.
- Latency: data_ready sampled in IDLE gives 14 cycles with modwait=1 (STORE through SUB4). The result is valid in R0 in the IDLE cycle that follows.
- load_coeff arriving while busy is not accepted. The coefficient loader must wait for modwait==0 before pulsing load_coeff.
- Asynchronous reset mid-sequence returns to IDLE with coeff_idx=0 and all outputs 0 immediately.
- Unused state encodings go to IDLE.

Optional Feature:
FIR_STICKY_ERR_EN:
- Defined: EIDLE exits only on load_coeff. data_ready is ignored in EIDLE, with no modwait and no cnt_up. err stays 1 until LOADC is entered.
- Undefined: EIDLE exits as described in Behaviour.

Test Plan:
- Reset: n_rst=0 mid-MUL2 -> next observe IDLE with modwait=0, err=0, op=0, and coeff_idx=0 on the next load (dest=6).
- Four load_coeff pulses spaced 3 cycles -> dest=6,7,8,9 with op=3. clear=1 only on the dest=9 cycle. modwait pulses 1 cycle each.
- Coefficients F=1,1,1,1, then samples 10, 20, 30, 40 with overflow=0 -> each sample gives modwait high exactly 14 cycles and cnt_up once. The op/src/dest trace must match the state table exactly, e.g. SORT4 is op=1, src1=5, dest=1.
- overflow=1 forced in ADD3 -> next cycle err=1, modwait=0, op=0. A following data_ready enters STORE and err=0; without the macro, processing completes normally.
- data_ready dropped to 0 in the STORE cycle -> EIDLE with err=1, and cnt_up never asserted.
- load_coeff and data_ready asserted in the same IDLE cycle -> LOADC first, then STORE on the next IDLE because data_ready is still held. Total busy is 1+14 cycles.
